// File: rtl/ram_scrubber.sv
// ram_scrubber - background scrub controller for a small RAM.
//
// Each pass walks addresses 0..DEPTH-1, reads every word and compares it with
// a fixed golden pattern (GOLD_EVEN at even addresses, GOLD_ODD at odd ones).
// A mismatching word is rewritten with its golden value and read back; the
// read-back decides whether it counts as fixed or as a failure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a pass (only honoured in IDLE)
//   continuous        restart from address 0 after DONE instead of idling
//   addr, wr_data     RAM address / write data
//   rd_enable         RAM read strobe (data returns the following cycle)
//   wr_enable         RAM write strobe (never together with rd_enable)
//   rd_data           RAM read data
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//   fixed_count       words repaired this pass (saturating)
//   fail_count        words still wrong after rewrite (saturating)
//   err_flag          sticky failure flag, cleared by start
module ram_scrubber #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 12,
    parameter logic [DATA_W-1:0] GOLD_EVEN = 12'hFFF,
    parameter logic [DATA_W-1:0] GOLD_ODD  = 12'h000,
    parameter int                CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_enable,
    output logic              wr_enable,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  fixed_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              err_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_VREAD,
        S_VCHECK,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] golden;
    logic              match;
    logic              last;

    // control strobes from the next-state logic
    logic clr_cnt;
    logic addr_clr;
    logic addr_inc;
    logic wr_load;
    logic fix_inc;
    logic fail_inc;

    assign golden = addr[0] ? GOLD_ODD : GOLD_EVEN;
    assign match  = (rd_data == golden);
    assign last   = (addr == ADDR_W'(DEPTH - 1));

    // strobes are pure state decodes, so reset clears them asynchronously
    assign rd_enable = (state == S_READ) || (state == S_VREAD);
    assign wr_enable = (state == S_WRITE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        addr_clr  = 1'b0;
        addr_inc  = 1'b0;
        wr_load   = 1'b0;
        fix_inc   = 1'b0;
        fail_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr_cnt   = 1'b1;
                    addr_clr  = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = S_CHECK;
            S_CHECK: begin
                if (!match) begin
                    // latch the repair value now so it is stable during WRITE
                    wr_load   = 1'b1;
                    state_nxt = S_WRITE;
                end else if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_WRITE: state_nxt = S_VREAD;
            S_VREAD: state_nxt = S_VCHECK;
            S_VCHECK: begin
                fix_inc  = match;
                fail_inc = !match;
                if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_DONE: begin
                // counters deliberately survive a continuous restart
                if (continuous) begin
                    addr_clr  = 1'b1;
                    state_nxt = S_READ;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            wr_data     <= '0;
            fixed_count <= '0;
            fail_count  <= '0;
            err_flag    <= 1'b0;
        end else begin
            if (addr_clr)      addr <= '0;
            else if (addr_inc) addr <= addr + 1'b1;

            if (wr_load) wr_data <= golden;

            if (clr_cnt) begin
                fixed_count <= '0;
                fail_count  <= '0;
                err_flag    <= 1'b0;
            end else begin
                if (fix_inc && (fixed_count != '1)) fixed_count <= fixed_count + 1'b1;
                if (fail_inc) begin
                    err_flag <= 1'b1;
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_scrubber.sv
// tb_ram_scrubber - scoreboard bench for ram_scrubber.
// Expected RAM accesses and end-of-pass results are queued by the stimulus;
// monitors pop and compare them whenever the DUTs strobe the RAM or pulse done.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_ram_scrubber;

    typedef struct {
        logic        wr;
        int          addr;
        logic [11:0] data;
    } acc_t;

    typedef struct {
        int fixed;
        int fail;
        int err;
        int lat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n, start, continuous, start2;
    always #5 clk = ~clk;

    // DUT 1 (default parameters)
    logic [3:0]  addr;
    logic [11:0] wr_data, rd_data;
    logic        rd_enable, wr_enable, busy, done, err_flag;
    logic [7:0]  fixed_count, fail_count;

    // DUT 2 (CNT_W = 2)
    logic [3:0]  addr2;
    logic [11:0] wr_data2, rd_data2;
    logic        rd_enable2, wr_enable2, busy2, done2, err_flag2;
    logic [1:0]  fixed_count2, fail_count2;

    ram_scrubber u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .addr(addr), .wr_data(wr_data), .rd_enable(rd_enable), .wr_enable(wr_enable),
        .rd_data(rd_data), .busy(busy), .done(done), .fixed_count(fixed_count),
        .fail_count(fail_count), .err_flag(err_flag)
    );

    ram_scrubber #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .continuous(1'b0),
        .addr(addr2), .wr_data(wr_data2), .rd_enable(rd_enable2), .wr_enable(wr_enable2),
        .rd_data(rd_data2), .busy(busy2), .done(done2), .fixed_count(fixed_count2),
        .fail_count(fail_count2), .err_flag(err_flag2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int t0_2     = 0;

    acc_t exp_acc[$];
    res_t exp_res[$];
    res_t exp_res2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM models
    logic [11:0] mem [4];
    logic [11:0] load_val [4];
    logic        load;
    int          ign_addr;
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4; i++) mem[i] <= load_val[i];
        end else if (wr_enable && (int'(addr) != ign_addr)) begin
            mem[addr[1:0]] <= wr_data;
        end
        if (rd_enable) rd_data <= mem[addr[1:0]];
    end

    logic [11:0] mem2 [4];
    logic        load2;
    always @(posedge clk) begin
        if (load2) begin
            // every word inverted against its golden value
            mem2[0] <= 12'h000; mem2[1] <= 12'hFFF;
            mem2[2] <= 12'h000; mem2[3] <= 12'hFFF;
        end else if (wr_enable2) begin
            mem2[addr2[1:0]] <= wr_data2;
        end
        if (rd_enable2) rd_data2 <= mem2[addr2[1:0]];
    end

    // monitor for DUT 1
    acc_t mon_a;
    res_t mon_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_enable || wr_enable) begin
                check("strobe_excl", 32'(rd_enable & wr_enable), 0);
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_access: got wr=%0d addr=%0d expected none (cycle %0d)",
                             wr_enable, addr, cyc);
                end else begin
                    mon_a = exp_acc.pop_front();
                    check("acc_kind", 32'(wr_enable), 32'(mon_a.wr));
                    check("acc_addr", 32'(addr), mon_a.addr);
                    if (mon_a.wr) check("acc_wdata", 32'(wr_data), 32'(mon_a.data));
                end
            end
            if (done) begin
                check("done_busy_low", 32'(busy), 0);
                if (exp_res.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_r = exp_res.pop_front();
                    check("fixed_count", 32'(fixed_count), mon_r.fixed);
                    check("fail_count", 32'(fail_count), mon_r.fail);
                    check("err_flag", 32'(err_flag), mon_r.err);
                    check("done_latency", cyc - t0 + 1, mon_r.lat);
                end
            end
        end
    end

    // monitor for DUT 2
    res_t mon_r2;
    always @(negedge clk) begin
        if (rst_n && done2) begin
            check("done2_busy_low", 32'(busy2), 0);
            if (exp_res2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done2: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_r2 = exp_res2.pop_front();
                check("sat_fixed_count", 32'(fixed_count2), mon_r2.fixed);
                check("sat_fail_count", 32'(fail_count2), mon_r2.fail);
                check("sat_err_flag", 32'(err_flag2), mon_r2.err);
                check("sat_latency", cyc - t0_2 + 1, mon_r2.lat);
            end
        end
    end

    task automatic push_rd(input int a);
        exp_acc.push_back('{1'b0, a, 12'h000});
    endtask

    task automatic push_wr(input int a, input logic [11:0] d);
        exp_acc.push_back('{1'b1, a, d});
    endtask

    task automatic push_clean();
        for (int i = 0; i < 4; i++) push_rd(i);
    endtask

    task automatic push_res(input int f, input int fl, input int e, input int lat);
        exp_res.push_back('{f, fl, e, lat});
    endtask

    task automatic preload(input logic [11:0] v0, input logic [11:0] v1,
                           input logic [11:0] v2, input logic [11:0] v3);
        @(negedge clk);
        load_val[0] = v0; load_val[1] = v1; load_val[2] = v2; load_val[3] = v3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // start sampled at the next rising edge (E0); t0 is cyc after E0 = cycle 1
    task automatic go();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_pass();
        for (int i = 0; i < 300; i++) begin
            if (exp_res.size() == 0 && exp_res2.size() == 0) break;
            @(negedge clk);
        end
        check("pass_complete", exp_res.size() + exp_res2.size(), 0);
        repeat (4) @(negedge clk);
        check("acc_q_drained", exp_acc.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; continuous = 1'b0;
        load = 1'b0; load2 = 1'b0; ign_addr = -1;
        for (int i = 0; i < 4; i++) load_val[i] = 12'h000;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_addr", 32'(addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_rd_enable", 32'(rd_enable), 0);
        check("rst_wr_enable", 32'(wr_enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fixed", 32'(fixed_count), 0);
        check("rst_fail", 32'(fail_count), 0);
        check("rst_err", 32'(err_flag), 0);
        rst_n = 1'b1;

        // clean pass: four reads, no writes, done in cycle 9
        preload(12'hFFF, 12'h000, 12'hFFF, 12'h000);
        push_clean();
        push_res(0, 0, 0, 9);
        go();
        check("busy_cycle1", 32'(busy), 1);
        wait_pass();

        // one corrupted word repaired, done in cycle 12
        preload(12'hFFF, 12'h000, 12'h0F0, 12'h000);
        push_rd(0); push_rd(1); push_rd(2); push_wr(2, 12'hFFF); push_rd(2); push_rd(3);
        push_res(1, 0, 0, 12);
        go();
        wait_pass();
        check("mem2_repaired", 32'(mem[2]), 32'h0FFF);

        // stuck word: write ignored, counted as failure; rerun clears then re-sets
        ign_addr = 1;
        preload(12'hFFF, 12'h001, 12'hFFF, 12'h000);
        push_rd(0); push_rd(1); push_wr(1, 12'h000); push_rd(1); push_rd(2); push_rd(3);
        push_res(0, 1, 1, 12);
        go();
        wait_pass();
        check("err_sticky_idle", 32'(err_flag), 1);
        push_rd(0); push_rd(1); push_wr(1, 12'h000); push_rd(1); push_rd(2); push_rd(3);
        push_res(0, 1, 1, 12);
        go();
        check("err_cleared_by_start", 32'(err_flag), 0);
        check("fail_cleared_by_start", 32'(fail_count), 0);
        wait_pass();
        ign_addr = -1;

        // continuous: pass 1 repairs word 3, pass 2 is clean and keeps the count
        preload(12'hFFF, 12'h000, 12'hFFF, 12'h123);
        continuous = 1'b1;
        push_clean(); push_wr(3, 12'h000); push_rd(3);
        push_res(1, 0, 0, 12);
        push_clean();
        push_res(1, 0, 0, 21);
        go();
        while (cyc != t0 + 3) @(negedge clk);
        start = 1'b1;                       // ignored while busy
        @(negedge clk);
        start = 1'b0;
        while (cyc != t0 + 12) @(negedge clk);
        continuous = 1'b0;                  // pass 2 is in progress
        while (cyc != t0 + 20) @(negedge clk);
        check("done_pass2", 32'(done), 1);
        start = 1'b1;                       // ignored in DONE
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", 32'(busy), 0);
        wait_pass();
        check("mem3_repaired", 32'(mem[3]), 32'h0000);

        // reset asserted during WRITE
        preload(12'h555, 12'h000, 12'hFFF, 12'h000);
        push_rd(0); push_wr(0, 12'hFFF);
        go();
        @(negedge clk);
        @(negedge clk);
        check("in_write", 32'(wr_enable), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_enable", 32'(wr_enable), 0);
        check("arst_rd_enable", 32'(rd_enable), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_addr", 32'(addr), 0);
        check("arst_wr_data", 32'(wr_data), 0);
        check("arst_fixed", 32'(fixed_count), 0);
        check("arst_fail", 32'(fail_count), 0);
        check("arst_err", 32'(err_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_acc_drained", exp_acc.size(), 0);
        preload(12'hFFF, 12'h000, 12'hFFF, 12'h000);
        push_clean();
        push_res(0, 0, 0, 9);
        go();
        wait_pass();

        // saturation on the CNT_W=2 instance: four repairs, count stops at 3
        @(negedge clk);
        load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        exp_res2.push_back('{3, 0, 0, 21});
        @(negedge clk);
        start2 = 1'b1;
        t0_2 = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        wait_pass();
        check("sat_mem0", 32'(mem2[0]), 32'h0FFF);
        check("sat_mem1", 32'(mem2[1]), 32'h0000);
        check("sat_mem2", 32'(mem2[2]), 32'h0FFF);
        check("sat_mem3", 32'(mem2[3]), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_scrubber.md
Name: ram_scrubber

Overview:
- Scrub controller on the initiator side of the 12-bit scrubber RAM port (addr / wr_data / rd_data / rd_enable / wr_enable).
- On each pass it walks every RAM address, reads the word and compares it against a fixed golden pattern: even address = GOLD_EVEN, odd address = GOLD_ODD.
- A corrupted word is rewritten with its golden value and read back to confirm the repair.
- Corrected and uncorrectable words are counted and reported to the control logic through a start/busy/done handshake.

Parameters:
- DEPTH, 4, number of RAM words scrubbed per pass (>=2).
- ADDR_W, 4, width of the addr port; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 12, RAM word width.
- GOLD_EVEN, 12'hFFF, expected content of even addresses.
- GOLD_ODD, 12'h000, expected content of odd addresses.
- CNT_W, 8, width of the error counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scrub pass; sampled only in IDLE.
- continuous  input  1  when 1, DONE returns to address 0 instead of IDLE.
- addr  output  ADDR_W  RAM address.
- wr_data  output  DATA_W  RAM write data.
- rd_enable  output  1  RAM read strobe.
- wr_enable  output  1  RAM write strobe.
- rd_data  input  DATA_W  RAM read data; valid in the cycle after rd_enable.
- busy  output  1  pass in progress.
- done  output  1  one-cycle end-of-pass pulse.
- fixed_count  output  CNT_W  words corrected in the current or last pass; saturating.
- fail_count  output  CNT_W  words still wrong after rewrite; saturating.
- err_flag  output  1  sticky; set on any fail and cleared by start.

Behaviour:
- Reset:
  - rst_n low forces state IDLE, regardless of state; an aborted pass is not resumed.
  - Reset values: addr=0, wr_data=0, rd_enable=0, wr_enable=0, busy=0, done=0, fixed_count=0, fail_count=0, err_flag=0.
- Strobes:
  - rd_enable and wr_enable are never high in the same cycle. The RAM gives read priority, so asserting both would silently drop the write.
  - Outputs are decoded from the state.
- State machine:
  - IDLE:
    - If start=1 at the edge: clear both counters and err_flag, set addr=0, go to READ.
    - busy=0 in IDLE.
  - READ: rd_enable=1, busy=1 → CHECK.
  - CHECK: compare rd_data with golden(addr); golden = GOLD_EVEN when addr[0]=0, else GOLD_ODD.
    - Match and addr==DEPTH-1 → DONE.
    - Match otherwise → addr+1, go to READ.
    - Mismatch → WRITE.
  - WRITE: wr_enable=1, wr_data=golden(addr) → VREAD.
  - VREAD: rd_enable=1 → VCHECK.
  - VCHECK:
    - Match → fixed_count+1.
    - Mismatch → fail_count+1 and err_flag=1.
    - Then the same advance rule as CHECK: last address → DONE, otherwise addr+1 → READ.
  - DONE:
    - done=1 and busy=0 for exactly one cycle.
    - continuous=1 → addr=0, go to READ; counters are NOT cleared.
    - Otherwise → IDLE.
- Timing:
  - A clean word takes 2 cycles; a corrupted word takes 5 cycles.
  - A DEPTH=4 clean pass: start sampled at edge E0, READ addr0 in cycle 1, DONE in cycle 9.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- wr_data: holds its last value outside WRITE.
- start: ignored whenever the state is not IDLE, including DONE.
- Address: addr never exceeds DEPTH-1.
- Reset mid-write: the RAM word may or may not be written; a new pass must still produce correct results.

Test Plan:
- RAM preloaded FFF/000/FFF/000, pulse start → addresses 0,1,2,3 each read once; done in cycle 9; fixed_count=0, fail_count=0; wr_enable never high.
- RAM word 2 preset to 12'h0F0, start → exactly one write, to addr 2 with wr_data=FFF, followed by a re-read of addr 2; fixed_count=1; done in cycle 12; afterwards memory[2]=FFF.
- RAM model forced to ignore writes to addr 1, which is preset to 12'h001 → fail_count=1, err_flag=1, fixed_count=0. A following start clears err_flag and fail_count, which then become 1 again in that pass.
- continuous=1 with word 3 corrupted once → first pass fixed_count=1; second pass leaves fixed_count at 1; done pulses every pass; start pulses while busy have no effect.
- rst_n asserted during WRITE → all outputs take their reset values immediately (asynchronously); after release, a new start completes a clean pass with correct counts.
- CNT_W=2 with all 4 words corrupted → fixed_count saturates at 3 and does not wrap.
